// File: rtl/cnn_pkg.sv
// cnn_pkg: shared feature type, default geometry and pooling phase encoding
package cnn_pkg;
  localparam int FEAT_W    = 16;
  localparam int ROW_LANES = 30;
  localparam int MAP_ROWS  = 30;
  typedef logic signed [FEAT_W-1:0] feature_t;
  typedef enum logic {POOL_EVEN, POOL_ODD} pool_phase_e;
endpackage

// File: rtl/max2_signed.sv
// max2_signed: combinational two-input signed maximum
// a_i, b_i: operands (two's complement); y_o: the larger one, same width
module max2_signed #(
  parameter int DW = 16
) (
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic [DW-1:0] y_o
);
  assign y_o = ($signed(a_i) > $signed(b_i)) ? a_i : b_i;
endmodule

// File: rtl/max_pool_row_pair.sv
// max_pool_row_pair: 2x2 stride-2 signed max pooling over streamed rows
// clk/reset: clock, sync active-high reset; start: new-frame pulse
// valid_in/input_feature: one row of WIDTH lanes per valid cycle
// output_feature/ready_pool: pooled row of WIDTH/2 lanes and its one-cycle strobe
// frame_done: strobe on the last pooled row of a frame; row_count: next input row index
module max_pool_row_pair
  import cnn_pkg::*;
#(
  parameter int WIDTH = ROW_LANES,
  parameter int DW    = FEAT_W,
  parameter int ROWS  = MAP_ROWS
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         valid_in,
  input  logic [WIDTH:1][DW-1:0]       input_feature,
  output logic [WIDTH/2:1][DW-1:0]     output_feature,
  output logic                         ready_pool,
  output logic                         frame_done,
  output logic [$clog2(ROWS)-1:0]      row_count
);
  localparam int HW = WIDTH / 2;
  localparam int CW = $clog2(ROWS);
  localparam logic [CW-1:0] LAST = CW'(ROWS - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);
  if ((WIDTH % 2 != 0) || (ROWS % 2 != 0)) begin : g_bad_geometry
    $error("max_pool_row_pair: WIDTH and ROWS must both be even");
  end
  logic [HW:1][DW-1:0] h, v, buf_q, buf_d, out_q, out_d;
  logic [CW-1:0] cnt_q, cnt_d;
  pool_phase_e phase_q, phase_d;
  logic ready_q, ready_d, done_q, done_d;
  logic load, emit, last;
  for (genvar k = 1; k <= HW; k++) begin : g_lane
    max2_signed #(.DW(DW)) u_h (
      .a_i(input_feature[2*k-1]),
      .b_i(input_feature[2*k]),
      .y_o(h[k])
    );
    max2_signed #(.DW(DW)) u_v (
      .a_i(buf_q[k]),
      .b_i(h[k]),
      .y_o(v[k])
    );
  end
  // start discards a half-pooled pair, so a row arriving with it always opens a new pair
  assign load = valid_in & (start | (phase_q == POOL_EVEN));
  assign emit = valid_in & ~start & (phase_q == POOL_ODD);
  assign last = cnt_q == LAST;
  always_comb begin
    phase_d = load ? POOL_ODD : ((start | emit) ? POOL_EVEN : phase_q);
    cnt_d   = start ? (valid_in ? ONE : '0) : (valid_in ? (last ? '0 : cnt_q + ONE) : cnt_q);
    buf_d   = load ? h : buf_q;
    out_d   = emit ? v : out_q;
    ready_d = emit;
    done_d  = emit & last;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= POOL_EVEN;
      cnt_q   <= '0;
      buf_q   <= '0;
      out_q   <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      out_q   <= out_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end
  assign output_feature = out_q;
  assign ready_pool     = ready_q;
  assign frame_done     = done_q;
  assign row_count      = cnt_q;
endmodule
